mavg_pdet_pipe: RTL and testbench

Parametrised second-generation filter-and-detect pipeline: a runtime-selectable power-of-two moving-average filter feeding a three-point local-maximum/minimum peak detector with threshold, column gating and peak index reporting. It replaces the fixed-window moving-average plus peak-detector pair in the top-level, between the sample source and the peak consumer. It adds configurable depth and width, warm-up suppression, filter bypass and an explicit peak index output.

---
 rtl/mavg_pdet_pkg.sv | 29 ++
 rtl/mavg_pdet_pipe_if.sv | 39 +++
 rtl/mavg_win_fltr.sv | 95 +++++++++
 rtl/mavg_pdet_pipe.sv | 106 ++++++++++
 tb/tb_mavg_pdet_pipe.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mavg_pdet_pkg.sv
// Shared definitions for the moving-average / peak-detect pipeline:
// default widths, width helpers, window decode and detector history state.
package mavg_pdet_pkg;

  localparam int DATAWIDTH_DEF    = 16;
  localparam int MAX_WIN_LOG2_DEF = 4;
  localparam int IDXW_DEF         = 10;

  // How many filtered samples the detector has seen since it was last cleared.
  typedef enum logic [1:0] {
    HIST_0  = 2'd0,
    HIST_1  = 2'd1,
    HIST_2P = 2'd2
  } hist_e;

  function automatic int sum_width(input int data_w, input int max_win_log2);
    return data_w + max_win_log2;
  endfunction

  function automatic int param_width(input int max_win_log2);
    return (max_win_log2 > 1) ? $clog2(max_win_log2) : 1;
  endfunction

  // Window = 2^(param+1), clamped to the buffer depth; returns log2(window).
  function automatic int win_log2_sel(input int param, input int max_win_log2);
    return ((param + 1) > max_win_log2) ? max_win_log2 : (param + 1);
  endfunction

endpackage

// File: rtl/mavg_pdet_pipe_if.sv
// Sample stream, configuration and result bundle of the filter-and-detect pipe.
interface mavg_pdet_pipe_if #(
  parameter int DATAWIDTH    = 16,
  parameter int MAX_WIN_LOG2 = 4,
  parameter int IDXW         = 10
);
  import mavg_pdet_pkg::*;

  localparam int PW = param_width(MAX_WIN_LOG2);

  logic                 start_act;
  logic                 movavg_en;
  logic                 vald_din;
  logic [DATAWIDTH-1:0] data_in;
  logic [PW-1:0]        movavgwin_param;
  logic                 pdet_en;
  logic [DATAWIDTH-1:0] peaktreshold_param;
  logic                 inverse_data_out;
  logic [IDXW-1:0]      active_columns_start;

  logic [DATAWIDTH-1:0] filt_data;
  logic                 filt_valid;
  logic [DATAWIDTH-1:0] peak_info;
  logic [IDXW-1:0]      peak_idx;
  logic                 peak_valid;

  modport master (
    output start_act, movavg_en, vald_din, data_in, movavgwin_param, pdet_en,
           peaktreshold_param, inverse_data_out, active_columns_start,
    input  filt_data, filt_valid, peak_info, peak_idx, peak_valid
  );

  modport slave (
    input  start_act, movavg_en, vald_din, data_in, movavgwin_param, pdet_en,
           peaktreshold_param, inverse_data_out, active_columns_start,
    output filt_data, filt_valid, peak_info, peak_idx, peak_valid
  );

endinterface

// File: rtl/mavg_win_fltr.sv
// Power-of-two moving-average filter: circular sample buffer, running sum,
// saturating fill counter with warm-up suppression, and registered bypass.
module mavg_win_fltr
  import mavg_pdet_pkg::*;
#(
  parameter int DATAWIDTH    = DATAWIDTH_DEF,
  parameter int MAX_WIN_LOG2 = MAX_WIN_LOG2_DEF,
  parameter int PW           = param_width(MAX_WIN_LOG2_DEF)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_act,
  input  logic                 movavg_en,
  input  logic                 vald_din,
  input  logic [DATAWIDTH-1:0] data_in,
  input  logic [PW-1:0]        movavgwin_param,
  output logic [DATAWIDTH-1:0] filt_data,
  output logic                 filt_valid
);

  localparam int DEPTH = 1 << MAX_WIN_LOG2;
  localparam int SW    = sum_width(DATAWIDTH, MAX_WIN_LOG2);
  localparam int LW    = $clog2(MAX_WIN_LOG2 + 1);
  localparam int FW    = MAX_WIN_LOG2 + 1;

  logic [DATAWIDTH-1:0]    sample_buf [DEPTH];
  logic [MAX_WIN_LOG2-1:0] wr_ptr;
  logic [MAX_WIN_LOG2-1:0] rd_ptr;
  logic [SW-1:0]           sum_q;
  logic [SW-1:0]           sum_next;
  logic [FW-1:0]           fill_q;
  logic [FW-1:0]           fill_next;
  logic [FW-1:0]           win_len;
  logic [LW-1:0]           win_log2;
  logic [DATAWIDTH-1:0]    old_sample;
  logic [DATAWIDTH-1:0]    avg;
  logic                    full;

  // NOTE: every signal driven in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    win_len    = FW'(1) << win_log2;
    full       = (fill_q == win_len);
    // Wraps modulo the buffer depth; at the largest window it reads the slot
    // about to be overwritten, which still holds x[n-W].
    rd_ptr     = wr_ptr - win_len[MAX_WIN_LOG2-1:0];
    old_sample = full ? sample_buf[rd_ptr] : '0;
    sum_next   = sum_q + SW'(data_in) - SW'(old_sample);
    fill_next  = full ? fill_q : fill_q + FW'(1);
    avg        = DATAWIDTH'(sum_next >> win_log2);
  end

  // NOTE: the sample buffer has no reset; entries are only read once the
  // fill counter proves they were written since the last start/reset.
  always_ff @(posedge clk) begin
    if (reset_n && !start_act && vald_din) begin
      sample_buf[wr_ptr] <= data_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      sum_q      <= '0;
      fill_q     <= '0;
      win_log2   <= LW'(1);
      filt_data  <= '0;
      filt_valid <= 1'b0;
    end else if (start_act) begin
      // A sample arriving with start_act is discarded.
      wr_ptr     <= '0;
      sum_q      <= '0;
      fill_q     <= '0;
      win_log2   <= LW'(win_log2_sel(int'(movavgwin_param), MAX_WIN_LOG2));
      filt_valid <= 1'b0;
    end else begin
      filt_valid <= 1'b0;
      if (vald_din) begin
        wr_ptr <= wr_ptr + MAX_WIN_LOG2'(1);
        sum_q  <= sum_next;
        fill_q <= fill_next;
        if (!movavg_en) begin
          filt_data  <= data_in;
          filt_valid <= 1'b1;
        end else if (fill_next == win_len) begin
          filt_data  <= avg;
          filt_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mavg_pdet_pipe.sv
// Filter-and-detect pipeline: moving-average filter followed by a three-point
// local max/min detector with threshold, column gating and peak index.
module mavg_pdet_pipe
  import mavg_pdet_pkg::*;
#(
  parameter int DATAWIDTH    = DATAWIDTH_DEF,
  parameter int MAX_WIN_LOG2 = MAX_WIN_LOG2_DEF,
  parameter int IDXW         = IDXW_DEF
) (
  input logic             clk,
  input logic             reset_n,
  mavg_pdet_pipe_if.slave bus
);

  localparam int PW = param_width(MAX_WIN_LOG2);

  logic [DATAWIDTH-1:0] filt_data;
  logic                 filt_valid;

  mavg_win_fltr #(
    .DATAWIDTH    (DATAWIDTH),
    .MAX_WIN_LOG2 (MAX_WIN_LOG2),
    .PW           (PW)
  ) u_fltr (
    .clk             (clk),
    .reset_n         (reset_n),
    .start_act       (bus.start_act),
    .movavg_en       (bus.movavg_en),
    .vald_din        (bus.vald_din),
    .data_in         (bus.data_in),
    .movavgwin_param (bus.movavgwin_param),
    .filt_data       (filt_data),
    .filt_valid      (filt_valid)
  );

  logic [DATAWIDTH-1:0] y1_q;
  logic [DATAWIDTH-1:0] y2_q;
  logic [IDXW-1:0]      idx_q;
  logic [IDXW-1:0]      idx1_q;
  hist_e                hist_q;
  logic [DATAWIDTH-1:0] v0;
  logic [DATAWIDTH-1:0] v1;
  logic [DATAWIDTH-1:0] v2;
  logic                 is_peak;
  logic                 peak_valid_q;
  logic [DATAWIDTH-1:0] peak_info_q;
  logic [IDXW-1:0]      peak_idx_q;

  // Compare values are taken from the raw history so a change of
  // inverse_data_out applies to the whole three-point window at once.
  always_comb begin
    v0      = bus.inverse_data_out ? ~filt_data : filt_data;
    v1      = bus.inverse_data_out ? ~y1_q      : y1_q;
    v2      = bus.inverse_data_out ? ~y2_q      : y2_q;
    is_peak = (hist_q == HIST_2P)
           && (v1 >  v2)
           && (v1 >= v0)
           && (v1 >= bus.peaktreshold_param)
           && (idx1_q >= bus.active_columns_start);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      y1_q         <= '0;
      y2_q         <= '0;
      idx_q        <= '0;
      idx1_q       <= '0;
      hist_q       <= HIST_0;
      peak_valid_q <= 1'b0;
      peak_info_q  <= '0;
      peak_idx_q   <= '0;
    end else if (bus.start_act) begin
      idx_q        <= '0;
      hist_q       <= HIST_0;
      peak_valid_q <= 1'b0;
    end else begin
      peak_valid_q <= 1'b0;
      if (!bus.pdet_en) begin
        hist_q <= HIST_0;
      end
      if (filt_valid) begin
        y2_q   <= y1_q;
        y1_q   <= filt_data;
        idx1_q <= idx_q;
        if (idx_q != {IDXW{1'b1}}) begin
          idx_q <= idx_q + IDXW'(1);
        end
        if (bus.pdet_en) begin
          hist_q <= (hist_q == HIST_0) ? HIST_1 : HIST_2P;
          if (is_peak) begin
            peak_valid_q <= 1'b1;
            peak_info_q  <= y1_q;
            peak_idx_q   <= idx1_q;
          end
        end
      end
    end
  end

  assign bus.filt_data  = filt_data;
  assign bus.filt_valid = filt_valid;
  assign bus.peak_valid = peak_valid_q;
  assign bus.peak_info  = peak_info_q;
  assign bus.peak_idx   = peak_idx_q;

endmodule

// File: tb/tb_mavg_pdet_pipe.sv
// Bench for mavg_pdet_pipe: directed scenarios plus randomized segments, every
// output checked each cycle against a sample-list reference model.
module tb_mavg_pdet_pipe;

  localparam int DW      = 16;
  localparam int MWL     = 4;
  localparam int IW      = 10;
  localparam int IDX_MAX = (1 << IW) - 1;

  logic clk = 1'b0;
  logic reset_n;

  mavg_pdet_pipe_if #(.DATAWIDTH(DW), .MAX_WIN_LOG2(MWL), .IDXW(IW)) bus ();

  mavg_pdet_pipe #(.DATAWIDTH(DW), .MAX_WIN_LOG2(MWL), .IDXW(IW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int dut_peaks;

  // Reference model state
  logic [DW-1:0] samp_q [$];
  int            n_acc;
  int            m_wlog2;
  logic          m_fv;
  logic [DW-1:0] m_fd;
  logic [DW-1:0] det_y [$];
  int            det_i [$];
  int            m_idx;
  logic          m_pv;
  logic [DW-1:0] m_pi;
  logic [IW-1:0] m_px;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] vmap(input logic [DW-1:0] y);
    return bus.inverse_data_out ? ~y : y;
  endfunction

  task automatic model_reset();
    samp_q.delete();
    n_acc   = 0;
    m_wlog2 = 1;
    m_fv    = 1'b0;
    m_fd    = '0;
    det_y.delete();
    det_i.delete();
    m_idx   = 0;
    m_pv    = 1'b0;
    m_pi    = '0;
    m_px    = '0;
  endtask

  // One clock cycle: drive inputs, advance the model, check all outputs.
  task automatic step(input bit vld, input logic [DW-1:0] din,
                      input bit start = 1'b0, input bit rst_n = 1'b1);
    int sz;
    int w;
    int unsigned s;
    @(negedge clk);
    bus.vald_din  = vld;
    bus.data_in   = din;
    bus.start_act = start;
    reset_n       = rst_n;

    if (!rst_n) begin
      model_reset();
    end else begin
      // Detector consumes the filtered sample presented during this cycle.
      if (start) begin
        det_y.delete();
        det_i.delete();
        m_idx = 0;
        m_pv  = 1'b0;
      end else begin
        m_pv = 1'b0;
        if (!bus.pdet_en) begin
          det_y.delete();
          det_i.delete();
        end
        if (m_fv) begin
          int i;
          i = m_idx;
          if (m_idx < IDX_MAX) m_idx++;
          if (bus.pdet_en) begin
            det_y.push_back(m_fd);
            det_i.push_back(i);
            sz = det_y.size();
            if (sz >= 3) begin
              if (vmap(det_y[sz-2]) > vmap(det_y[sz-3]) &&
                  vmap(det_y[sz-2]) >= vmap(det_y[sz-1]) &&
                  vmap(det_y[sz-2]) >= bus.peaktreshold_param &&
                  det_i[sz-2] >= int'(bus.active_columns_start)) begin
                m_pv = 1'b1;
                m_pi = det_y[sz-2];
                m_px = IW'(det_i[sz-2]);
              end
              void'(det_y.pop_front());
              void'(det_i.pop_front());
            end
          end
        end
      end
      // Filter: mean of the most recent W samples accepted since start.
      if (start) begin
        samp_q.delete();
        n_acc   = 0;
        m_wlog2 = (int'(bus.movavgwin_param) + 1 > MWL) ? MWL : int'(bus.movavgwin_param) + 1;
        m_fv    = 1'b0;
      end else if (vld) begin
        samp_q.push_back(din);
        if (samp_q.size() > (1 << MWL)) void'(samp_q.pop_front());
        if (n_acc < 1000000) n_acc++;
        w = 1 << m_wlog2;
        if (!bus.movavg_en) begin
          m_fd = din;
          m_fv = 1'b1;
        end else if (n_acc >= w) begin
          s = 0;
          for (int k = samp_q.size() - w; k < samp_q.size(); k++) s += samp_q[k];
          m_fd = DW'(s >> m_wlog2);
          m_fv = 1'b1;
        end else begin
          m_fv = 1'b0;
        end
      end else begin
        m_fv = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    check("filt_valid", bus.filt_valid, m_fv);
    check("filt_data",  bus.filt_data,  m_fd);
    check("peak_valid", bus.peak_valid, m_pv);
    check("peak_info",  bus.peak_info,  m_pi);
    check("peak_idx",   bus.peak_idx,   m_px);
    if (bus.peak_valid === 1'b1) dut_peaks++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0);
  endtask

  initial begin
    reset_n                  = 1'b0;
    bus.start_act            = 1'b0;
    bus.movavg_en            = 1'b1;
    bus.vald_din             = 1'b0;
    bus.data_in              = '0;
    bus.movavgwin_param      = '0;
    bus.pdet_en              = 1'b0;
    bus.peaktreshold_param   = '0;
    bus.inverse_data_out     = 1'b0;
    bus.active_columns_start = '0;
    model_reset();

    // Reset state
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 16'd77, 1'b0, 1'b0);
    check("rst_filt_valid", bus.filt_valid, 0);
    check("rst_peak_valid", bus.peak_valid, 0);
    check("rst_filt_data",  bus.filt_data,  0);

    // W=4: 4,8,12,16,20 -> 10,14
    bus.movavgwin_param = 2'd1;
    step(1'b0, '0, 1'b1);
    step(1'b1, 16'd4);
    step(1'b1, 16'd8);
    step(1'b1, 16'd12);
    check("w4_warmup", bus.filt_valid, 0);
    step(1'b1, 16'd16);
    check("w4_first_valid", bus.filt_valid, 1);
    check("w4_first", bus.filt_data, 16'd10);
    step(1'b1, 16'd20);
    check("w4_second", bus.filt_data, 16'd14);
    idle(2);

    // Bypass peak 1,5,3 threshold 2
    bus.movavg_en = 1'b0;
    bus.pdet_en = 1'b1;
    bus.peaktreshold_param = 16'd2;
    step(1'b0, '0, 1'b1);
    dut_peaks = 0;
    step(1'b1, 16'd1);
    step(1'b1, 16'd5);
    step(1'b1, 16'd3);
    check("byp_no_early_peak", bus.peak_valid, 0);
    step(1'b0, '0);
    check("byp_peak_valid", bus.peak_valid, 1);
    check("byp_peak_info", bus.peak_info, 16'd5);
    check("byp_peak_idx", bus.peak_idx, 1);
    idle(2);
    check("byp_peak_count", dut_peaks, 1);

    // Plateau 1,6,6,2: single peak at idx 1, then none with threshold 7
    bus.peaktreshold_param = 16'd0;
    step(1'b0, '0, 1'b1);
    dut_peaks = 0;
    step(1'b1, 16'd1); step(1'b1, 16'd6); step(1'b1, 16'd6); step(1'b1, 16'd2);
    idle(3);
    check("plateau_count", dut_peaks, 1);
    check("plateau_idx", bus.peak_idx, 1);
    bus.peaktreshold_param = 16'd7;
    step(1'b0, '0, 1'b1);
    dut_peaks = 0;
    step(1'b1, 16'd1); step(1'b1, 16'd6); step(1'b1, 16'd6); step(1'b1, 16'd2);
    idle(3);
    check("plateau_thr_count", dut_peaks, 0);

    // Valley detection 9,2,7; then column gating suppresses it
    bus.inverse_data_out = 1'b1;
    bus.peaktreshold_param = 16'd0;
    step(1'b0, '0, 1'b1);
    dut_peaks = 0;
    step(1'b1, 16'd9); step(1'b1, 16'd2); step(1'b1, 16'd7);
    idle(3);
    check("valley_count", dut_peaks, 1);
    check("valley_info", bus.peak_info, 16'd2);
    check("valley_idx", bus.peak_idx, 1);
    bus.active_columns_start = 10'd2;
    step(1'b0, '0, 1'b1);
    dut_peaks = 0;
    step(1'b1, 16'd9); step(1'b1, 16'd2); step(1'b1, 16'd7);
    idle(3);
    check("valley_gated_count", dut_peaks, 0);
    bus.active_columns_start = '0;
    bus.inverse_data_out = 1'b0;

    // W=16 saturated stream, then start_act with a sample mid-stream
    bus.movavg_en = 1'b1;
    bus.movavgwin_param = 2'd3;
    step(1'b0, '0, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b1, 16'hFFFF);
    check("w16_full_scale", bus.filt_data, 16'hFFFF);
    step(1'b1, 16'h1234, 1'b1);
    check("w16_start_drop", bus.filt_valid, 0);
    for (int k = 0; k < 17; k++) step(1'b1, DW'(k * 100));
    check("w16_rewarm", bus.filt_valid, 1);

    // Reset mid-stream
    step(1'b1, 16'd500, 1'b0, 1'b0);
    check("midrst_filt_valid", bus.filt_valid, 0);
    check("midrst_peak_info", bus.peak_info, 0);
    check("midrst_filt_data", bus.filt_data, 0);

    // Detector disable clears history; peak only after two new samples
    bus.movavg_en = 1'b0;
    bus.pdet_en = 1'b1;
    bus.peaktreshold_param = 16'd0;
    step(1'b0, '0, 1'b1);
    dut_peaks = 0;
    step(1'b1, 16'd1); step(1'b1, 16'd5); step(1'b0, '0);
    bus.pdet_en = 1'b0;
    step(1'b0, '0);
    bus.pdet_en = 1'b1;
    step(1'b1, 16'd3); step(1'b1, 16'd2); step(1'b1, 16'd8); step(1'b1, 16'd3);
    step(1'b0, '0);
    check("reen_count", dut_peaks, 1);
    check("reen_idx", bus.peak_idx, 4);
    check("reen_info", bus.peak_info, 16'd8);

    // Index saturation with alternating peaks
    step(1'b0, '0, 1'b1);
    for (int k = 0; k < 1032; k++) step(1'b1, (k % 2) ? 16'd5 : 16'd0);
    idle(2);
    check("idx_saturated", bus.peak_idx, IDX_MAX);

    // Randomized segments
    for (int seg = 0; seg < 30; seg++) begin
      bus.movavgwin_param      = 2'($urandom_range(0, 3));
      bus.movavg_en            = 1'($urandom_range(0, 3) != 0);
      bus.pdet_en              = 1'($urandom_range(0, 4) != 0);
      bus.inverse_data_out     = 1'($urandom_range(0, 1));
      bus.peaktreshold_param   = ($urandom_range(0, 1) != 0) ? '0 : DW'($urandom);
      bus.active_columns_start = IW'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1);
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 15) == 0) bus.pdet_en = ~bus.pdet_en;
        if ($urandom_range(0, 39) == 0) begin
          bus.movavgwin_param = 2'($urandom_range(0, 3));
          step(1'b1, DW'($urandom), 1'b1);
        end else begin
          step(1'($urandom_range(0, 3) != 0),
               (seg % 2) ? DW'($urandom) : DW'($urandom_range(0, 7)));
        end
      end
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
